// File: rtl/shift_right_ctrl_if.sv
// ---------------------------------------------------------------------------
// shift_right_ctrl_if
// Purpose : bundles the request/response handshake of shift_right_ctrl.
// Signals :
//    in_valid / in_ready        request handshake (requester -> block)
//    in_data[49:0]              operand, ten 5-bit groups (group g = [5g+4:5g])
//    in_amt[3:0]                shift amount in groups
//    in_fill[4:0]               pattern written into vacated groups
//    out_valid / out_ready      result handshake (block -> consumer)
//    out_data[49:0]             shifted result
//    busy                       block is not idle
//    out_err                    only with SHIFT_RIGHT_CTRL_ERR_EN: amount > 10
// Modports: master = requester/consumer side, slave = shift_right_ctrl.
// ---------------------------------------------------------------------------
interface shift_right_ctrl_if;
   logic        in_valid;
   logic        in_ready;
   logic [49:0] in_data;
   logic [3:0]  in_amt;
   logic [4:0]  in_fill;
   logic        out_valid;
   logic        out_ready;
   logic [49:0] out_data;
   logic        busy;
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
   logic        out_err;
`endif

   modport master (
      output in_valid, in_data, in_amt, in_fill, out_ready,
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
      input  out_err,
`endif
      input  in_ready, out_valid, out_data, busy
   );

   modport slave (
      input  in_valid, in_data, in_amt, in_fill, out_ready,
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
      output out_err,
`endif
      output in_ready, out_valid, out_data, busy
   );
endinterface

// File: rtl/shift_right_ctrl.sv
// ---------------------------------------------------------------------------
// shift_right_ctrl
// Purpose : multi-cycle right shift of a 50-bit word by whole 5-bit groups.
//           The shift is done in passes of at most 4 groups per cycle, with
//           in_fill written into every vacated group. The result is held in
//           DONE until the consumer accepts it.
// Ports   :
//    clk   rising-edge clock
//    rst   synchronous active-high reset
//    bus   shift_right_ctrl_if.slave (request/response handshake, busy)
// Config  : define SHIFT_RIGHT_CTRL_ERR_EN to add bus.out_err, flagging a
//           requested amount above 10. Without it, such amounts are treated
//           as 10.
// ---------------------------------------------------------------------------
module shift_right_ctrl (
   input  logic                 clk,
   input  logic                 rst,
   shift_right_ctrl_if.slave    bus
);

   typedef enum logic [1:0] {
      IDLE  = 2'd0,
      SHIFT = 2'd1,
      DONE  = 2'd2
   } state_t;

   state_t      state_q, state_d;
   logic [49:0] work_q,  work_d;
   logic [4:0]  fill_q,  fill_d;
   logic [3:0]  rem_q,   rem_d;

   logic [3:0]  step;
   logic [3:0]  rem_after;
   logic [49:0] shifted;

   // Groups of the working register extended by four copies of the fill,
   // so that a pass of up to 4 groups can index past group 9 without any
   // out-of-range selection.
   logic [4:0]  ext_grp [0:13];

   assign step      = (rem_q > 4'd4) ? 4'd4 : rem_q;
   assign rem_after = rem_q - step;

   generate
      for (genvar gi = 0; gi < 14; gi++) begin : g_ext
         if (gi < 10) begin : g_word
            assign ext_grp[gi] = work_q[gi*5 +: 5];
         end else begin : g_fill
            assign ext_grp[gi] = fill_q;
         end
      end
      for (genvar gi = 0; gi < 10; gi++) begin : g_shift
         logic [3:0] src_idx;
         assign src_idx              = 4'(gi) + step;
         assign shifted[gi*5 +: 5]   = ext_grp[src_idx];
      end
   endgenerate

`ifdef SHIFT_RIGHT_CTRL_ERR_EN
   logic err_q, err_d;
`endif

   always_comb begin
      state_d = state_q;
      work_d  = work_q;
      fill_d  = fill_q;
      rem_d   = rem_q;
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
      err_d   = err_q;
`endif
      case (state_q)
         IDLE: begin
            if (bus.in_valid) begin
               work_d  = bus.in_data;
               fill_d  = bus.in_fill;
               // Amounts above 10 clear every group, exactly like 10.
               rem_d   = (bus.in_amt > 4'd10) ? 4'd10 : bus.in_amt;
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
               err_d   = (bus.in_amt > 4'd10);
`endif
               state_d = (bus.in_amt == 4'd0) ? DONE : SHIFT;
            end
         end
         SHIFT: begin
            work_d = shifted;
            rem_d  = rem_after;
            if (rem_after == 4'd0) begin
               state_d = DONE;
            end
         end
         DONE: begin
            if (bus.out_ready) begin
               state_d = IDLE;
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
               err_d   = 1'b0;
`endif
            end
         end
         default: begin
            state_d = IDLE;
         end
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= IDLE;
         work_q  <= '0;
         fill_q  <= '0;
         rem_q   <= '0;
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
         err_q   <= 1'b0;
`endif
      end else begin
         state_q <= state_d;
         work_q  <= work_d;
         fill_q  <= fill_d;
         rem_q   <= rem_d;
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
         err_q   <= err_d;
`endif
      end
   end

   assign bus.in_ready  = (state_q == IDLE);
   assign bus.out_valid = (state_q == DONE);
   assign bus.busy      = (state_q != IDLE);
   assign bus.out_data  = work_q;
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
   assign bus.out_err   = err_q;
`endif

endmodule

// File: tb/tb_shift_right_ctrl.sv
// ---------------------------------------------------------------------------
// tb_shift_right_ctrl
// Purpose : directed self-checking bench for shift_right_ctrl. Inputs are
//           driven 1 time unit after the rising edge and outputs sampled at
//           the same point, away from the active edge.
// ---------------------------------------------------------------------------
module tb_shift_right_ctrl;

   logic clk = 1'b0;
   logic rst;

   always #5 clk = ~clk;

   shift_right_ctrl_if bus ();

   shift_right_ctrl dut (
      .clk (clk),
      .rst (rst),
      .bus (bus.slave)
   );

   int n_checks = 0;
   int n_pass   = 0;
   int n_fail   = 0;

   task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
      n_checks++;
      assert (obs === exp) n_pass++;
      else begin
         n_fail++;
         $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Presents one request, takes the accept edge, then counts edges (the
   // accept edge being edge 1) until out_valid is seen, bounded at 20.
   task automatic run_req(input logic [49:0] d, input logic [3:0] a,
                          input logic [4:0] f, output int edges);
      bus.in_valid = 1'b1;
      bus.in_data  = d;
      bus.in_amt   = a;
      bus.in_fill  = f;
      tick();
      edges = 1;
      bus.in_valid = 1'b0;
      while (bus.out_valid !== 1'b1 && edges < 20) begin
         tick();
         edges++;
      end
      $display("txn amt=%0d fill=0x%0h edges=%0d out_data=0x%013h", a, f, edges, bus.out_data);
   endtask

   // Consumer accepts the held result; block must be idle afterwards.
   task automatic release_result(input string tag);
      bus.out_ready = 1'b1;
      tick();
      bus.out_ready = 1'b0;
      chk({tag, "_idle_busy"}, 64'(bus.busy), 64'd0);
   endtask

   logic [49:0] d_ramp;
   logic [49:0] d_hold;
   int          edges;

   initial begin
      d_ramp = {5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1, 5'd0};

      bus.in_valid  = 1'b0;
      bus.in_data   = '0;
      bus.in_amt    = '0;
      bus.in_fill   = '0;
      bus.out_ready = 1'b0;
      rst           = 1'b1;
      tick();
      tick();
      rst = 1'b0;

      // Reset state
      chk("rst_in_ready",  64'(bus.in_ready),  64'd1);
      chk("rst_out_valid", 64'(bus.out_valid), 64'd0);
      chk("rst_busy",      64'(bus.busy),      64'd0);
      chk("rst_out_data",  64'(bus.out_data),  64'd0);

      // Zero shift with consumer always ready: one DONE cycle only
      bus.out_ready = 1'b1;
      run_req(50'h3_FFFF_FFFF_FFFF, 4'd0, 5'h00, edges);
      chk("zero_latency", 64'(edges), 64'd1);
      chk("zero_data",    64'(bus.out_data), 64'h3_FFFF_FFFF_FFFF);
      chk("zero_busy",    64'(bus.busy), 64'd1);
      chk("zero_ready",   64'(bus.in_ready), 64'd0);
      tick();
      bus.out_ready = 1'b0;
      chk("zero_busy_after", 64'(bus.busy), 64'd0);
      chk("zero_valid_after", 64'(bus.out_valid), 64'd0);

      // Shift 7 with fill 0x1F: passes of 4 and 3
      run_req(d_ramp, 4'd7, 5'h1F, edges);
      chk("s7_latency", 64'(edges), 64'd3);
      chk("s7_data", 64'(bus.out_data),
          64'({5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'h1F, 5'd9, 5'd8, 5'd7}));
      release_result("s7");

      // Shift 1 with zero fill: single pass
      run_req(d_ramp, 4'd1, 5'h00, edges);
      chk("s1_latency", 64'(edges), 64'd2);
      chk("s1_data", 64'(bus.out_data),
          64'({5'd0, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));
      release_result("s1");

      // Shift 4 exactly fills one pass
      run_req(d_ramp, 4'd4, 5'h15, edges);
      chk("s4_latency", 64'(edges), 64'd2);
      chk("s4_data", 64'(bus.out_data),
          64'({5'h15, 5'h15, 5'h15, 5'h15, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4}));
      release_result("s4");

      // Maximum shift: passes 4,4,2, all fill
      run_req(50'h1_2345_6789_ABCD, 4'd10, 5'h0A, edges);
      chk("s10_latency", 64'(edges), 64'd4);
      chk("s10_data", 64'(bus.out_data), 64'({10{5'h0A}}));
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
      chk("s10_err", 64'(bus.out_err), 64'd0);
`endif
      release_result("s10");

      // Out-of-range shift behaves as 10
      run_req(50'h2_FEDC_BA98_7654, 4'd15, 5'h0A, edges);
      chk("s15_latency", 64'(edges), 64'd4);
      chk("s15_data", 64'(bus.out_data), 64'({10{5'h0A}}));
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
      chk("s15_err", 64'(bus.out_err), 64'd1);
`endif
      release_result("s15");
`ifdef SHIFT_RIGHT_CTRL_ERR_EN
      chk("s15_err_clr", 64'(bus.out_err), 64'd0);
`endif

      // Backpressure: result held while new requests are offered
      run_req(d_ramp, 4'd1, 5'h03, edges);
      chk("bp_latency", 64'(edges), 64'd2);
      for (int i = 0; i < 5; i++) begin
         bus.in_valid = 1'b1;
         bus.in_amt   = 4'd0;
         bus.in_data  = 50'(64'h0001_1111_1111_1111 * (i + 1));
         tick();
         $display("hold cycle=%0d out_valid=%0d in_ready=%0d out_data=0x%013h",
                  i, bus.out_valid, bus.in_ready, bus.out_data);
         chk("bp_data", 64'(bus.out_data),
             64'({5'h03, 5'd9, 5'd8, 5'd7, 5'd6, 5'd5, 5'd4, 5'd3, 5'd2, 5'd1}));
         chk("bp_in_ready", 64'(bus.in_ready), 64'd0);
         chk("bp_valid", 64'(bus.out_valid), 64'd1);
      end
      d_hold       = 50'h3_0F0F_0F0F_0F0F;
      bus.in_data  = d_hold;
      bus.out_ready = 1'b1;
      tick();                       // release edge: must not accept
      bus.out_ready = 1'b0;
      chk("bp_release_busy", 64'(bus.busy), 64'd0);
      chk("bp_release_ready", 64'(bus.in_ready), 64'd1);
      tick();                       // in_valid still high: accept now
      bus.in_valid = 1'b0;
      chk("bp_next_valid", 64'(bus.out_valid), 64'd1);
      chk("bp_next_data", 64'(bus.out_data), 64'(d_hold));
      release_result("bp_next");

      // Reset on the second SHIFT cycle of a 10-group request
      bus.in_valid = 1'b1;
      bus.in_data  = 50'h1_5555_5555_5555;
      bus.in_amt   = 4'd10;
      bus.in_fill  = 5'h11;
      tick();                       // accept
      bus.in_valid = 1'b0;
      chk("mid_busy1", 64'(bus.busy), 64'd1);
      tick();                       // first SHIFT pass done
      chk("mid_busy2", 64'(bus.busy), 64'd1);
      rst = 1'b1;
      tick();
      rst = 1'b0;
      $display("reset mid-op out_valid=%0d in_ready=%0d out_data=0x%013h",
               bus.out_valid, bus.in_ready, bus.out_data);
      chk("mid_valid", 64'(bus.out_valid), 64'd0);
      chk("mid_data", 64'(bus.out_data), 64'd0);
      chk("mid_ready", 64'(bus.in_ready), 64'd1);
      chk("mid_busy", 64'(bus.busy), 64'd0);
      for (int i = 0; i < 4; i++) begin
         tick();
         chk("mid_no_valid", 64'(bus.out_valid), 64'd0);
      end

      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule
